// File: rtl/ff_ptr_ctrl.sv
// ff_ptr_ctrl: per-channel FIFO pointer, occupancy, status-flag and sticky-error control.
// Every output is registered. The flags are derived from the next occupancy, so they stay in step with ff_occ.
module ff_ptr_ctrl #(
    parameter int FF_DEPTH  = 16,
    parameter int NUM_INTFS = 1,
    parameter int AFULL_TH  = FF_DEPTH - 2,
    parameter int AEMPTY_TH = 2,
    localparam int PTR_W    = $clog2(FF_DEPTH),
    localparam int OCC_W    = $clog2(FF_DEPTH + 1)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_INTFS-1:0]       ff_flush,
    input  logic [NUM_INTFS-1:0]       ff_wr_en,
    input  logic [NUM_INTFS-1:0]       ff_rd_en,
    input  logic [NUM_INTFS-1:0]       ff_clr_err,
    output logic [NUM_INTFS*PTR_W-1:0] ff_wr_ptr,
    output logic [NUM_INTFS*PTR_W-1:0] ff_rd_ptr,
    output logic [NUM_INTFS*OCC_W-1:0] ff_occ,
    output logic [NUM_INTFS-1:0]       ff_full,
    output logic [NUM_INTFS-1:0]       ff_empty,
    output logic [NUM_INTFS-1:0]       ff_afull,
    output logic [NUM_INTFS-1:0]       ff_aempty,
    output logic [NUM_INTFS-1:0]       ff_ovrflw,
    output logic [NUM_INTFS-1:0]       ff_undrflw
);
    for (genvar i = 0; i < NUM_INTFS; i++) begin : g_ch
        logic [PTR_W-1:0] wp, rp;
        logic [OCC_W-1:0] occ, occ_n;
        logic full, empty, afull, aempty, ovr, und, wacc, racc;
        // Flush masks both requests, so it can neither move a pointer nor raise an error.
        assign wacc  = ff_wr_en[i] & ~full & ~ff_flush[i];
        assign racc  = ff_rd_en[i] & ~empty & ~ff_flush[i];
        assign occ_n = ff_flush[i] ? '0 : occ + OCC_W'(wacc) - OCC_W'(racc);
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wp     <= '0;
                rp     <= '0;
                occ    <= '0;
                full   <= 1'b0;
                empty  <= 1'b1;
                afull  <= 1'b0;
                aempty <= 1'b1;
                ovr    <= 1'b0;
                und    <= 1'b0;
            end else begin
                wp     <= ff_flush[i] ? '0 : !wacc ? wp : wp == PTR_W'(FF_DEPTH - 1) ? '0 : wp + PTR_W'(1);
                rp     <= ff_flush[i] ? '0 : !racc ? rp : rp == PTR_W'(FF_DEPTH - 1) ? '0 : rp + PTR_W'(1);
                occ    <= occ_n;
                full   <= occ_n == OCC_W'(FF_DEPTH);
                empty  <= occ_n == '0;
                afull  <= occ_n >= OCC_W'(AFULL_TH);
                aempty <= occ_n <= OCC_W'(AEMPTY_TH);
                ovr    <= (~ff_flush[i] & ff_wr_en[i] & full) | (ovr & ~ff_clr_err[i]);
                und    <= (~ff_flush[i] & ff_rd_en[i] & empty) | (und & ~ff_clr_err[i]);
            end
        end
        assign ff_wr_ptr[i*PTR_W +: PTR_W] = wp;
        assign ff_rd_ptr[i*PTR_W +: PTR_W] = rp;
        assign ff_occ[i*OCC_W +: OCC_W]    = occ;
        assign ff_full[i]                  = full;
        assign ff_empty[i]                 = empty;
        assign ff_afull[i]                 = afull;
        assign ff_aempty[i]                = aempty;
        assign ff_ovrflw[i]                = ovr;
        assign ff_undrflw[i]               = und;
    end
endmodule

// File: tb/tb_ff_ptr_ctrl.sv
// tb_ff_ptr_ctrl: checks a 2-channel depth-16 instance and a 1-channel depth-12 instance
// against an occupancy-count reference model, using directed scenarios and then random traffic.
module tb_ff_ptr_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [2:0] flush = '0, wr = '0, rd = '0, clr = '0;
    logic [7:0] a_wp, a_rp;
    logic [9:0] a_occ;
    logic [1:0] a_full, a_empty, a_afull, a_aempty, a_ovr, a_und;
    logic [3:0] b_wp, b_rp, b_occ;
    logic b_full, b_empty, b_afull, b_aempty, b_ovr, b_und;
    int n_chk = 0, n_err = 0;
    int dep[3]  = '{16, 16, 12};
    int ath[3]  = '{14, 14, 9};
    int aeth[3] = '{2, 2, 3};
    int m_occ[3], m_wp[3], m_rp[3];
    bit m_ovr[3], m_und[3];

    always #5 clk = ~clk;

    ff_ptr_ctrl #(.FF_DEPTH(16), .NUM_INTFS(2)) u_a (
        .clk(clk), .rst_n(rst_n), .ff_flush(flush[1:0]), .ff_wr_en(wr[1:0]),
        .ff_rd_en(rd[1:0]), .ff_clr_err(clr[1:0]), .ff_wr_ptr(a_wp), .ff_rd_ptr(a_rp),
        .ff_occ(a_occ), .ff_full(a_full), .ff_empty(a_empty), .ff_afull(a_afull),
        .ff_aempty(a_aempty), .ff_ovrflw(a_ovr), .ff_undrflw(a_und)
    );

    ff_ptr_ctrl #(.FF_DEPTH(12), .NUM_INTFS(1), .AFULL_TH(9), .AEMPTY_TH(3)) u_b (
        .clk(clk), .rst_n(rst_n), .ff_flush(flush[2]), .ff_wr_en(wr[2]),
        .ff_rd_en(rd[2]), .ff_clr_err(clr[2]), .ff_wr_ptr(b_wp), .ff_rd_ptr(b_rp),
        .ff_occ(b_occ), .ff_full(b_full), .ff_empty(b_empty), .ff_afull(b_afull),
        .ff_aempty(b_aempty), .ff_ovrflw(b_ovr), .ff_undrflw(b_und)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 3; c++) begin
            m_occ[c] = 0; m_wp[c] = 0; m_rp[c] = 0; m_ovr[c] = 0; m_und[c] = 0;
        end
    endtask

    // Flag word order: full, empty, afull, aempty, ovrflw, undrflw.
    task automatic check_all(input string tag);
        for (int c = 0; c < 3; c++) begin
            int gwp, grp, gocc, gfl, efl;
            gwp  = c < 2 ? int'(a_wp[c*4 +: 4]) : int'(b_wp);
            grp  = c < 2 ? int'(a_rp[c*4 +: 4]) : int'(b_rp);
            gocc = c < 2 ? int'(a_occ[c*5 +: 5]) : int'(b_occ);
            gfl  = c < 2 ? int'({a_full[c], a_empty[c], a_afull[c], a_aempty[c], a_ovr[c], a_und[c]})
                         : int'({b_full, b_empty, b_afull, b_aempty, b_ovr, b_und});
            efl  = int'({m_occ[c] == dep[c], m_occ[c] == 0, m_occ[c] >= ath[c],
                         m_occ[c] <= aeth[c], m_ovr[c], m_und[c]});
            check($sformatf("%s ch%0d wr_ptr", tag, c), gwp, m_wp[c]);
            check($sformatf("%s ch%0d rd_ptr", tag, c), grp, m_rp[c]);
            check($sformatf("%s ch%0d occ", tag, c), gocc, m_occ[c]);
            check($sformatf("%s ch%0d flags", tag, c), gfl, efl);
        end
    endtask

    // Reference model: a FIFO seen only as an item count with modulo-depth addresses.
    task automatic cyc(input string tag);
        for (int c = 0; c < 3; c++) begin
            bit is_full, is_empty, w, r;
            is_full  = m_occ[c] == dep[c];
            is_empty = m_occ[c] == 0;
            if (flush[c]) begin
                m_occ[c] = 0; m_wp[c] = 0; m_rp[c] = 0;
                m_ovr[c] = m_ovr[c] && !clr[c];
                m_und[c] = m_und[c] && !clr[c];
            end else begin
                w = wr[c] && !is_full;
                r = rd[c] && !is_empty;
                m_wp[c]  = (m_wp[c] + int'(w)) % dep[c];
                m_rp[c]  = (m_rp[c] + int'(r)) % dep[c];
                m_occ[c] = m_occ[c] + int'(w) - int'(r);
                m_ovr[c] = (wr[c] && is_full) || (m_ovr[c] && !clr[c]);
                m_und[c] = (rd[c] && is_empty) || (m_und[c] && !clr[c]);
            end
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic drive(input logic [2:0] f, input logic [2:0] w, input logic [2:0] r,
                         input logic [2:0] c, input int n, input string tag);
        flush = f; wr = w; rd = r; clr = c;
        for (int k = 0; k < n; k++) cyc(tag);
        flush = '0; wr = '0; rd = '0; clr = '0;
    endtask

    initial begin
        model_reset();
        #12;
        check_all("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive(3'b000, 3'b001, 3'b000, 3'b000, 16, "fill16");
        check("fill16 wp", int'(a_wp[3:0]), 0);
        drive(3'b000, 3'b001, 3'b000, 3'b000, 1, "wr17");
        check("wr17 ovr", int'(a_ovr[0]), 1);
        drive(3'b000, 3'b001, 3'b001, 3'b000, 1, "full_wr_rd");
        check("full_wr_rd occ", int'(a_occ[4:0]), 15);
        drive(3'b000, 3'b001, 3'b000, 3'b000, 1, "refill");
        drive(3'b000, 3'b001, 3'b000, 3'b001, 1, "clr_vs_set");
        check("clr_vs_set ovr", int'(a_ovr[0]), 1);
        drive(3'b000, 3'b000, 3'b000, 3'b001, 1, "clr_alone");
        check("clr_alone ovr", int'(a_ovr[0]), 0);
        drive(3'b000, 3'b000, 3'b001, 3'b000, 16, "drain");
        drive(3'b000, 3'b001, 3'b001, 3'b000, 1, "empty_wr_rd");
        check("empty_wr_rd und", int'(a_und[0]), 1);
        drive(3'b000, 3'b100, 3'b000, 3'b000, 12, "b_fill");
        drive(3'b000, 3'b000, 3'b100, 3'b000, 12, "b_drain");
        drive(3'b000, 3'b100, 3'b000, 3'b000, 3, "b_wrap");
        check("b_wrap wp", int'(b_wp), 3);
        drive(3'b111, 3'b000, 3'b000, 3'b111, 1, "flush_all");
        drive(3'b000, 3'b001, 3'b000, 3'b000, 5, "ch0_to5");
        drive(3'b000, 3'b010, 3'b000, 3'b000, 2, "ch1_to2");
        drive(3'b001, 3'b011, 3'b001, 3'b000, 1, "flush_ch0");
        check("flush_ch0 ch1 occ", int'(a_occ[9:5]), 3);
        drive(3'b000, 3'b001, 3'b000, 3'b000, 7, "to7");
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        #2 rst_n = 1'b1;
        drive(3'b000, 3'b111, 3'b000, 3'b000, 1, "post_rst_wr");
        check("post_rst_wr wp", int'(a_wp[3:0]), 1);
        for (int k = 0; k < 3000; k++) begin
            int pw;
            pw = ((k / 100) % 2) ? 30 : 70;
            for (int c = 0; c < 3; c++) begin
                wr[c]    = $urandom_range(0, 99) < pw;
                rd[c]    = $urandom_range(0, 99) < 100 - pw;
                flush[c] = $urandom_range(0, 99) < 2;
                clr[c]   = $urandom_range(0, 99) < 5;
            end
            cyc("random");
        end
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/ff_ptr_ctrl.md
FF_PTR_CTRL -- requirements
Module: ff_ptr_ctrl

Interface
REQ-001 SHALL have parameter FF_DEPTH, default 16, entries per channel; any integer >= 2, power of two not required.
REQ-002 SHALL have parameter NUM_INTFS, default 1, number of independent channels.
REQ-003 SHALL have parameter AFULL_TH, default FF_DEPTH-2, almost-full occupancy threshold.
REQ-004 SHALL have parameter AEMPTY_TH, default 2, almost-empty occupancy threshold.
REQ-005 SHALL have derived parameter PTR_W = clog2(FF_DEPTH) and OCC_W = clog2(FF_DEPTH+1); neither is overridden.
REQ-006 clk  input  1  clock; all logic on rising edge.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 ff_flush  input  NUM_INTFS  per-channel synchronous flush.
REQ-009 ff_wr_en  input  NUM_INTFS  per-channel write request.
REQ-010 ff_rd_en  input  NUM_INTFS  per-channel read request.
REQ-011 ff_clr_err  input  NUM_INTFS  per-channel clear of sticky error flags.
REQ-012 ff_wr_ptr  output  PTR_W x NUM_INTFS  write address per channel.
REQ-013 ff_rd_ptr  output  PTR_W x NUM_INTFS  read address per channel.
REQ-014 ff_occ  output  OCC_W x NUM_INTFS  occupancy per channel, range 0..FF_DEPTH.
REQ-015 ff_full / ff_empty  output  NUM_INTFS each  full / empty flags.
REQ-016 ff_afull / ff_aempty  output  NUM_INTFS each  almost-full / almost-empty flags.
REQ-017 ff_ovrflw / ff_undrflw  output  NUM_INTFS each  sticky overflow / underflow flags.

Function
REQ-018 All outputs SHALL be registered; channels SHALL be fully independent.
REQ-019 Write accepted (wacc) SHALL be ff_wr_en & ~ff_full; read accepted (racc) SHALL be ff_rd_en & ~ff_empty, both evaluated on current registered flags.
REQ-020 On wacc, ff_wr_ptr SHALL advance by 1, wrapping FF_DEPTH-1 -> 0; on racc, ff_rd_ptr likewise.
REQ-021 ff_occ SHALL update to occ + wacc - racc in one cycle; wacc and racc together leave occ unchanged.
REQ-022 ff_full/ff_empty/ff_afull/ff_aempty SHALL be computed from the next occupancy: ==FF_DEPTH, ==0, >=AFULL_TH, <=AEMPTY_TH; flags valid same cycle as ff_occ.
REQ-023 Write+read while empty: read rejected, write accepted, occ -> 1, ff_empty deasserts next cycle.
REQ-024 Write+read while full: write rejected, read accepted, occ -> FF_DEPTH-1, ff_full deasserts next cycle.
REQ-025 ff_ovrflw SHALL set when ff_wr_en & ff_full; ff_undrflw SHALL set when ff_rd_en & ff_empty; both hold until ff_clr_err.
REQ-026 Same-cycle set and ff_clr_err: set SHALL win.
REQ-027 ff_flush SHALL override that channel's wr/rd: pointers 0, occ 0, empty 1, aempty 1, full 0, afull 0 next cycle; error flags unaffected; no error set during flush.

Reset
REQ-028 On rst_n low, all channels SHALL immediately go to: pointers 0, occ 0, ff_empty 1, ff_aempty 1, ff_full 0, ff_afull 0, ff_ovrflw 0, ff_undrflw 0.
REQ-029 Reset asserted mid-operation SHALL discard all state; first accepted write after release SHALL target address 0.

Verification
REQ-030 FF_DEPTH=16: 16 writes -> occ 16, full 1, afull from occ 14; 17th write -> ovrflw 1, wr_ptr stays 0.
REQ-031 FF_DEPTH=12: 12 writes, 12 reads, 3 writes -> wr_ptr 3, rd_ptr 0, occ 3, pointers wrapped 11 -> 0.
REQ-032 Empty, wr_en+rd_en same cycle -> occ 1, undrflw 1, rd_ptr 0; full, wr_en+rd_en -> occ 15, ovrflw 1.
REQ-033 NUM_INTFS=2: fill ch0 to 5, flush ch0 while writing ch1 -> ch0 occ 0, ptrs 0; ch1 unaffected.
REQ-034 Set ovrflw, then ff_clr_err with concurrent overflow -> flag stays 1; clr_err alone next cycle -> 0.
REQ-035 Occ 7, assert rst_n low between edges -> all outputs at reset values immediately; after release, first write -> wr_ptr 1, occ 1.
